// File: rtl/sseg_mux_driver.sv
// Synchronises and debounces CorrectStation, converts the ADC code to degrees and BCD, and scans the result onto a 7-segment display.
// valid comes 10 cycles after the trigger; there is no backpressure, and a trigger that arrives while busy is dropped.
module sseg_mux_driver #(
    parameter int DIGITS         = 3,
    parameter int ADC_W          = 12,
    parameter int OFFSET         = 23,
    parameter int SCALE_NUM      = 967,
    parameter int SCALE_SHIFT    = 16,
    parameter int STABLE_CYCLES  = 4,
    parameter int SCAN_DIV       = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CorrectStation,
    input  logic [ADC_W-1:0]  digitalTemp,
    output logic [7:0]        decimalTemp,
    output logic              valid,
    output logic              busy,
    output logic              display,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int LIMIT  = (DIGITS >= 3) ? 1000 : (DIGITS == 2) ? 100 : 10;

    typedef enum logic [1:0] {IDLE, SCALE, BCD, DONE} state_t;

    state_t             state, state_nxt;
    logic               sync_a, sync_b;
    logic [CNT_W-1:0]   filt_cnt;
    logic               trig;
    logic [ADC_W-1:0]   raw_r;
    logic [7:0]         bin_r;
    logic [19:0]        dd_r;
    logic [2:0]         it_r;
    logic [7:0]         dec_r;
    logic [11:0]        bcd_disp;
    logic               held;
    logic               disp_r;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         dig_idx;

    logic [31:0]        prod;
    logic [31:0]        scaled;
    logic [7:0]         bin_calc;
    logic [19:0]        dd_adj, dd_step;
    logic [3:0]         digit;
    logic               blank;
    logic               overflow;
    logic [6:0]         seg_on;
    logic [DIGITS-1:0]  an_on;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            filt_cnt <= '0;
            trig     <= 1'b0;
        end else begin
            sync_a <= CorrectStation;
            sync_b <= sync_a;
            trig   <= 1'b0;
            if (!sync_b) begin
                filt_cnt <= '0;
            end else if (filt_cnt != CNT_W'(STABLE_CYCLES)) begin
                filt_cnt <= filt_cnt + 1'b1;
                trig     <= (filt_cnt == CNT_W'(STABLE_CYCLES - 1));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = SCALE;
            SCALE:   state_nxt = BCD;
            BCD:     if (it_r == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prod     = (32'(raw_r) - 32'(OFFSET)) * 32'(SCALE_NUM) + 32'(1 << (SCALE_SHIFT - 1));
        scaled   = prod >> SCALE_SHIFT;
        bin_calc = (32'(raw_r) < 32'(OFFSET)) ? 8'd0 :
                   (scaled > 32'd255)         ? 8'd255 : scaled[7:0];
    end

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
    always_comb begin
        dd_adj = dd_r;
        for (int k = 0; k < 3; k++) begin
            if (dd_adj[8 + 4*k +: 4] >= 4'd5)
                dd_adj[8 + 4*k +: 4] = dd_adj[8 + 4*k +: 4] + 4'd3;
        end
        dd_step = {dd_adj[18:0], 1'b0};
    end

    // Results are written on the last BCD step so they are already visible while valid is high in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            raw_r    <= '0;
            bin_r    <= '0;
            dd_r     <= '0;
            it_r     <= '0;
            dec_r    <= '0;
            bcd_disp <= '0;
        end else begin
            case (state)
                IDLE:  if (trig) raw_r <= digitalTemp;
                SCALE: begin
                    bin_r <= bin_calc;
                    dd_r  <= {12'd0, bin_calc};
                    it_r  <= '0;
                end
                BCD: begin
                    dd_r <= dd_step;
                    it_r <= it_r + 1'b1;
                    if (it_r == 3'd7) begin
                        dec_r    <= bin_r;
                        bcd_disp <= dd_step[19:8];
                    end
                end
                default: ;
            endcase
        end
    end

    // held remembers that the station has stayed present since the trigger that started this conversion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            held   <= 1'b0;
            disp_r <= 1'b0;
        end else begin
            if (!sync_b)                    held <= 1'b0;
            else if (trig && state == IDLE) held <= 1'b1;
            disp_r <= disp_r ? sync_b
                             : (valid && held && sync_b && filt_cnt == CNT_W'(STABLE_CYCLES));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == 2'(DIGITS - 1)) ? 2'd0 : dig_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        digit    = 4'd0;
        blank    = 1'b1;
        seg_on   = 7'h00;
        an_on    = '0;
        overflow = (32'(dec_r) >= 32'(LIMIT));
        case (dig_idx)
            2'd0: begin digit = bcd_disp[3:0];  blank = 1'b0; end
            2'd1: begin digit = bcd_disp[7:4];  blank = (bcd_disp[11:4] == 8'd0); end
            2'd2: begin digit = bcd_disp[11:8]; blank = (bcd_disp[11:8] == 4'd0); end
            default: blank = 1'b1;
        endcase
        if (disp_r) begin
            an_on  = DIGITS'(1) << dig_idx;
            seg_on = overflow ? 7'h40 : (blank ? 7'h00 : seg7(digit));
        end
    end

    assign decimalTemp = dec_r;
    assign valid       = (state == DONE);
    assign busy        = (state != IDLE);
    assign display     = disp_r;
    assign seg         = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    assign an          = (SEG_ACTIVE_LOW != 0) ? ~an_on  : an_on;
endmodule

// File: tb/tb_sseg_mux_driver.sv
// Scoreboard bench: expected temperatures are queued when a station request is issued and popped on valid; a DIGITS=1 copy covers the overflow dash.
module tb_sseg_mux_driver;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CorrectStation;
    logic [11:0] digitalTemp;
    logic [7:0]  decimalTemp, decimalTemp1;
    logic        valid, busy, display, valid1, busy1, display1;
    logic [6:0]  seg, seg1;
    logic [2:0]  an;
    logic [0:0]  an1;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    sseg_mux_driver dut (
        .CLK(CLK), .RST(RST), .CorrectStation(CorrectStation), .digitalTemp(digitalTemp),
        .decimalTemp(decimalTemp), .valid(valid), .busy(busy), .display(display),
        .seg(seg), .an(an)
    );

    sseg_mux_driver #(.DIGITS(1)) dut1 (
        .CLK(CLK), .RST(RST), .CorrectStation(CorrectStation), .digitalTemp(digitalTemp),
        .decimalTemp(decimalTemp1), .valid(valid1), .busy(busy1), .display(display1),
        .seg(seg1), .an(an1)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pops the next expected value.
    always @(negedge CLK) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("valid_data", int'(decimalTemp), e);
                check("valid_data_d1", int'(decimalTemp1), e);
                check("valid_d1", int'(valid1), 1);
            end
        end
    end

    // Waits up to 40 cycles for valid; n is the cycle count, fb the cycle where busy first appeared.
    task automatic wait_valid(output int n, output int fb);
        n  = 0;
        fb = -1;
        while (n < 40) begin
            @(negedge CLK);
            n++;
            if (busy && fb < 0) fb = n;
            if (valid) break;
        end
    endtask

    task automatic check_off(input string name);
        check({name, "_display"}, int'(display), 0);
        check({name, "_an"}, int'(an), 7);
        check({name, "_seg"}, int'(seg), 'h7F);
    endtask

    task automatic check_display(input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] ed1);
        int prev = -1;
        int run  = 0;
        bit full = 0;
        for (int c = 0; c < 16; c++) begin
            int idx = -1;
            int nz  = 0;
            logic [6:0] want;
            logic [6:0] want1;
            @(negedge CLK);
            for (int i = 0; i < 3; i++) if (an[i] == 1'b0) begin nz++; idx = i; end
            check("an_onehot", nz, 1);
            want  = ~((idx == 0) ? e0 : (idx == 1) ? e1 : e2);
            want1 = ~ed1;
            check("seg_digit", int'(seg), int'(want));
            check("d1_seg", int'(seg1), int'(want1));
            check("d1_an", int'(an1), 0);
            if (idx != prev) begin
                if (prev >= 0) begin
                    check("scan_order", idx, (prev + 1) % 3);
                    if (full) check("scan_period", run, 4);
                    full = 1;
                end
                prev = idx;
                run  = 1;
            end else begin
                run++;
            end
        end
    endtask

    task automatic run_conv(input int raw, input int val, input logic [6:0] e0,
                            input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] ed1);
        int n, fb;
        digitalTemp = 12'(raw);
        exp_q.push_back(val);
        CorrectStation = 1'b1;
        wait_valid(n, fb);
        check("lat_station", n, 16);
        check("lat_trigger", n - fb, 9);
        @(negedge CLK);
        check("display_on", int'(display), 1);
        check_display(e0, e1, e2, ed1);
        CorrectStation = 1'b0;
        repeat (4) @(negedge CLK);
        check_off("after_drop");
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int n, fb;
        bit seen;
        RST = 1'b1;
        CorrectStation = 1'b0;
        digitalTemp = '0;
        repeat (3) @(negedge CLK);
        check("rst_decimal", int'(decimalTemp), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check_off("rst");
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run_conv(362,  5,  7'h6D, 7'h00, 7'h00, 7'h6D);
        run_conv(1379, 20, 7'h3F, 7'h5B, 7'h00, 7'h40);
        run_conv(1718, 25, 7'h6D, 7'h5B, 7'h00, 7'h40);
        run_conv(2395, 35, 7'h6D, 7'h4F, 7'h00, 7'h40);

        seen = 0;
        for (int i = 0; i < 100; i++) begin
            CorrectStation = ((i / 2) % 2) == 0;
            @(negedge CLK);
            if (busy) seen = 1;
        end
        CorrectStation = 1'b0;
        repeat (4) @(negedge CLK);
        check("toggle_busy", int'(seen), 0);

        run_conv(10,   0,  7'h3F, 7'h00, 7'h00, 7'h3F);
        run_conv(4095, 60, 7'h3F, 7'h7D, 7'h00, 7'h40);

        digitalTemp = 12'd1379;
        exp_q.push_back(20);
        CorrectStation = 1'b1;
        n = 0;
        while (!busy && n < 40) begin @(negedge CLK); n++; end
        repeat (2) @(negedge CLK);
        CorrectStation = 1'b0;
        n = 0;
        while (!valid && n < 40) begin @(negedge CLK); n++; end
        check("drop_latency", n, 7);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (display || an != 3'b111) seen = 1;
        end
        check("drop_display_stays_off", int'(seen), 0);

        digitalTemp = 12'd1718;
        CorrectStation = 1'b1;
        n = 0;
        while (!busy && n < 40) begin @(negedge CLK); n++; end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        CorrectStation = 1'b0;
        @(negedge CLK);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_decimal", int'(decimalTemp), 0);
        check_off("abort");
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
